// File: rtl/mem_access_unit.sv
//==============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store initiator for a whole-word memory port pair; sub-word
//            stores use read-modify-write. Optional macro: MAU_STATS_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_access_unit #(
  parameter int MEM_WORDS         = 1024,
  parameter int LOAD_SEXT_DEFAULT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_wen
`ifdef MAU_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_MERGE   = 3'd2,
    S_CAPTURE = 3'd3,
    S_WRITE   = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  localparam logic [31:0] c_mem_words = 32'(MEM_WORDS);

  // Sign-extension is chosen per request; this parameter is reserved at 0.
  generate
    if (LOAD_SEXT_DEFAULT != 0) begin : g_sext_default_check
      $error("mem_access_unit: LOAD_SEXT_DEFAULT is reserved and must be 0");
    end
  endgenerate

  state_t      state_q;
  logic        wr_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [29:0] idx_q;
  logic [15:0] wdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] mem_raddr_q;
  logic [31:0] mem_waddr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_wen_q;

  logic        accept_d;
  logic        err_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] capture_d;
  logic [31:0] merge_d;

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_raddr = mem_raddr_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  // Gating by rst keeps a reset landing in WRITE from committing the word.
  assign mem_wen   = mem_wen_q && !rst;

  always_comb begin
    accept_d = req_valid && req_ready;
    err_d    = (req_size == 2'b11)
            || ((req_size == 2'b01) && req_addr[0])
            || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
            || ({2'b00, req_addr[31:2]} >= c_mem_words);

    byte_d = mem_rdata[7:0];
    case (lane_q)
      2'd1:    byte_d = mem_rdata[15:8];
      2'd2:    byte_d = mem_rdata[23:16];
      2'd3:    byte_d = mem_rdata[31:24];
      default: byte_d = mem_rdata[7:0];
    endcase
    half_d = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (size_q)
      2'b00:   capture_d = {{24{signed_q & byte_d[7]}}, byte_d};
      2'b01:   capture_d = {{16{signed_q & half_d[15]}}, half_d};
      default: capture_d = mem_rdata;
    endcase

    merge_d = mem_rdata;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd1:    merge_d[15:8]  = wdata_q[7:0];
        2'd2:    merge_d[23:16] = wdata_q[7:0];
        2'd3:    merge_d[31:24] = wdata_q[7:0];
        default: merge_d[7:0]   = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merge_d[31:16] = wdata_q;
    end else begin
      merge_d[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      signed_q    <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      idx_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_wen_q   <= 1'b0;
    end else begin
      mem_wen_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            wr_q     <= req_wr;
            signed_q <= req_signed;
            size_q   <= req_size;
            lane_q   <= req_addr[1:0];
            idx_q    <= req_addr[31:2];
            wdata_q  <= req_wdata[15:0];
            if (err_d) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              state_q     <= S_RESP;
            end else if (req_wr && (req_size == 2'b10)) begin
              mem_waddr_q <= {2'b00, req_addr[31:2]};
              mem_wdata_q <= req_wdata;
              mem_wen_q   <= 1'b1;
              state_q     <= S_WRITE;
            end else begin
              mem_raddr_q <= {2'b00, req_addr[31:2]};
              state_q     <= S_READ;
            end
          end
        end
        S_READ: begin
          state_q <= wr_q ? S_MERGE : S_CAPTURE;
        end
        S_CAPTURE: begin
          rsp_rdata_q <= capture_d;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_MERGE: begin
          mem_waddr_q <= {2'b00, idx_q};
          mem_wdata_q <= merge_d;
          mem_wen_q   <= 1'b1;
          state_q     <= S_WRITE;
        end
        S_WRITE: begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MAU_STATS_EN
  logic [31:0] stat_loads_q;
  logic [31:0] stat_stores_q;
  logic [31:0] stat_errs_q;

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads_q  <= '0;
      stat_stores_q <= '0;
      stat_errs_q   <= '0;
    end else if ((state_q == S_RESP) && rsp_ready) begin
      if (rsp_err_q)
        stat_errs_q <= stat_errs_q + 32'd1;
      else if (wr_q)
        stat_stores_q <= stat_stores_q + 32'd1;
      else
        stat_loads_q <= stat_loads_q + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//==============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed plus random load/store checks against a byte-array model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_access_unit;
  localparam int MW = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_wr, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_wen;
`ifdef MAU_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  int checks = 0;
  int errors = 0;
  int wen_count = 0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  int n_loads = 0, n_stores = 0, n_errs = 0;

  logic [31:0] mem [MW];
  logic [7:0]  ref_mem [MW*4];

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(MW), .LOAD_SEXT_DEFAULT(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wen(mem_wen)
`ifdef MAU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  // Memory environment: synchronous read, write on rising edge.
  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_waddr[5:0]] <= mem_wdata;
      wen_count  <= wen_count + 1;
      last_waddr <= mem_waddr;
      last_wdata <= mem_wdata;
    end
    mem_rdata <= mem[mem_raddr[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
  endfunction

  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= MW);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] addr);
    int n = 1 << size;
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(addr) + i]) << (8 * i);
    if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata);
    int n = 1 << size;
    for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
  endtask

  task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, output logic [31:0] rdata);
    bit err = model_err(size, addr);
    int exp_lat, lat;
    int wen0 = wen_count;
    logic [31:0] exp_rd = 32'h0;
    if (!err && !wr) exp_rd = model_load(size, sgn, addr);
    exp_lat = err ? 1 : (!wr ? 3 : (size == 2'd2 ? 2 : 4));

    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, err});
    check("rsp_rdata", rsp_rdata, exp_rd);
    rdata = rsp_rdata;

    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h4;
      @(negedge clk);
      check("hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, exp_rd);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
    check("req_ready_after", {31'b0, req_ready}, 32'd1);
    check("wen_pulses", wen_count - wen0, (!err && wr) ? 1 : 0);

    if (err) n_errs++;
    else if (wr) n_stores++;
    else n_loads++;
    if (!err && wr) begin
      model_store(size, addr, wdata);
      check("waddr", last_waddr, addr >> 2);
      check("wdata", last_wdata, ref_word(int'(addr >> 2)));
    end
  endtask

  initial begin
    logic [31:0] rd, w;
    int wen0;
    logic [1:0] sz;
    logic [31:0] a;

    for (int i = 0; i < MW; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i+b] = 8'(w >> (8 * b));
    end
    rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_mem_wen", {31'b0, mem_wen}, 32'd0);
    check("rst_mem_raddr", mem_raddr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_rsp_rdata", rsp_rdata, 32'h0);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd);
    check("ws_wdata_const", last_wdata, 32'hDEADBEEF);
    check("ws_waddr_const", last_waddr, 32'd4);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd);
    check("wl_const", rd, 32'hDEADBEEF);

    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0, rd);
    do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h00000080, 0, rd);
    check("bs_raddr", mem_raddr, 32'd4);
    check("bs_merge_const", last_wdata, 32'h11803344);
    do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 0, rd);
    check("lb_signed_const", rd, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 0, rd);
    check("lb_unsigned_const", rd, 32'h00000080);

    do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, rd);
    do_req(1'b1, 2'd2, 1'b0, 32'h0E, 32'h12345678, 0, rd);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 0, rd);
    do_req(1'b0, 2'd2, 1'b0, MW * 4, 32'h0, 0, rd);

    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 5, rd);

    // Reset landing in WRITE of a half store must not commit the merge.
    wen0 = wen_count;
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h16; req_wdata = 32'h0000ABCD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("write_state_wen", {31'b0, mem_wen_q_probe()}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_req_ready", {31'b0, req_ready}, 32'd0);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_mem_waddr", mem_waddr, 32'h0);
    check("abort_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    n_loads = 0; n_stores = 0; n_errs = 0;
    @(negedge clk);
    check("abort_no_write", wen_count - wen0, 32'd0);
    check("abort_mem_intact", mem[5], ref_word(5));
    do_req(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 0, rd);

    for (int k = 0; k < 40; k++) begin
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
      a = 32'($urandom_range(0, MW * 4 + 24));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 2), rd);
    end

    for (int i = 0; i < MW; i++) check("final_mem", mem[i], ref_word(i));

`ifdef MAU_STATS_EN
    check("stat_loads", stat_loads, n_loads);
    check("stat_stores", stat_stores, n_stores);
    check("stat_errs", stat_errs, n_errs);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic mem_wen_q_probe();
    return mem_wen;
  endfunction

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the single-port-pair word memory: turns pipeline load/store requests (byte/half/word, byte addressed) into word-indexed memory read/write port cycles.
- Sits between execute stage and the data memory.
- One outstanding request, valid/ready on both request and response sides.
- Sub-word stores use read-modify-write because the memory writes whole words only.

Parameters:
MEM_WORDS, 1024, number of 32-bit words behind the port; word index >= MEM_WORDS is an access error
LOAD_SEXT_DEFAULT, 0, not used by datapath; reserved, must stay 0

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept request
req_wr  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  input  1  loads: sign-extend sub-word result
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
rsp_valid  output  1  response present
rsp_ready  input  1  consumer takes response
rsp_rdata  output  32  load result (0 for stores and errors)
rsp_err  output  1  misaligned, illegal size or out-of-range
mem_raddr  output  32  word index to memory read port
mem_rdata  input  32  memory read data, valid the cycle after mem_raddr is sampled
mem_waddr  output  32  word index to memory write port
mem_wdata  output  32  full word to write
mem_wen  output  1  write enable, sampled by memory on rising edge

Behaviour:
- Reset values: req_ready=0 during the rst cycle and 1 after it; rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_raddr=0, mem_waddr=0, mem_wdata=0, mem_wen=0. State is IDLE.
- Word index is req_addr[31:2]. Byte lane is addr[1:0], little-endian: lane 0 = bits 7:0.
- States: IDLE, READ, MERGE, CAPTURE, WRITE, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid&req_ready and latch all request fields.
  - Error if any of: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2]>=MEM_WORDS. An error goes to RESP with rsp_err=1 and rsp_rdata=0. No memory port activity occurs.
  - Load goes to READ.
  - Word store goes to WRITE.
  - Byte/half store goes to READ.
- READ: mem_raddr=latched word index. Next state is CAPTURE for a load, MERGE for a store.
- CAPTURE: sample mem_rdata and select the lane. Zero-extend, or sign-extend if req_signed. Load into rsp_rdata and go to RESP.
- MERGE: sample mem_rdata and replace only the addressed byte/half with req_wdata[7:0] or [15:0]. Load the result into mem_wdata and go to WRITE.
- WRITE:
  - mem_wen=1 for exactly one cycle, with mem_waddr=word index.
  - mem_wdata = req_wdata for a word store, or the merged word.
  - Next state RESP, rsp_rdata=0.
- RESP: rsp_valid=1, held stable until rsp_ready; on handshake go to IDLE. req_ready=0 in every non-IDLE state.
- Latency from accept edge to rsp_valid high:
  - error: 1 cycle
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
- Back-to-back: with rsp_ready held 1, the next request is accepted the cycle after the RESP handshake.
- mem_wen is gated by !rst. rst asserted in any state, including WRITE, suppresses the write that edge and returns to IDLE. A partially merged store is discarded.
- mem_raddr/mem_waddr/mem_wdata hold their last values outside READ/WRITE. mem_wen=0 outside WRITE.
- req_* changes while req_ready=0 are ignored.

Optional Feature:
- MAU_STATS_EN defined: adds outputs stat_loads[31:0], stat_stores[31:0] and stat_errs[31:0].
  - Each counter increments by 1 on the RESP handshake of its class; error responses count only in stat_errs.
  - Counters are cleared by rst and wrap from 0xFFFFFFFF to 0.
- MAU_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> mem_wen pulse with waddr=4, wdata=0xDEADBEEF; load rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 3 cycles after accept.
- Byte store 0x80 @0x12 over word 0x11223344 -> read index 4, single write 0x11803344; signed byte load @0x12 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half load @0x11, word store @0x0E, size=11, addr=MEM_WORDS*4 -> rsp_err=1, rsp_rdata=0, 1-cycle latency, mem_wen never asserted.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, a second req_valid is not accepted until after the handshake.
- rst asserted while in WRITE of a half store -> no memory write occurs, outputs at reset values next cycle, next request is serviced normally.
- With MAU_STATS_EN: 3 loads, 2 stores, 1 error -> stat_loads=3, stat_stores=2, stat_errs=1.
